// File: rtl/lfsr_checker.sv
// Self-synchronising receive checker for a Fibonacci LFSR bit stream.
// Define LFSR_CHECKER_BITCNT_EN to add the locked valid-bit counter output bit_cnt_o.
module lfsr_checker #(
    parameter int unsigned     WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(16'hB400),
    parameter int unsigned     LOCK_CNT = 32,
    parameter int unsigned     WINDOW   = 64,
    parameter int unsigned     LOSS_ERR = 8,
    parameter int unsigned     ERR_W    = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             en_i,
    input  logic             bit_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [1:0]       state_o
`ifdef LFSR_CHECKER_BITCNT_EN
    ,
    output logic [31:0]      bit_cnt_o
`endif
);

    localparam int unsigned FW = $clog2(WIDTH + 1);
    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = $clog2(WINDOW + 1);
    localparam int unsigned EW = $clog2(LOSS_ERR + 1);

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [FW-1:0]    fill_q;
    logic [MW-1:0]    match_q;
    logic [WW-1:0]    win_q;
    logic [EW-1:0]    win_err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             err_q;
    logic             locked_q;

    logic             pred;
    logic             mismatch;
    logic [WIDTH-1:0] sh_rx_d;
    logic [WIDTH-1:0] sh_fly_d;

    always_comb begin
        pred     = ^(sh_q & TAPS);
        mismatch = bit_i ^ pred;
        sh_rx_d  = {sh_q[WIDTH-2:0], bit_i};
        // Once locked, the register free-runs on its own prediction so bit errors
        // cannot corrupt it.
        sh_fly_d = {sh_q[WIDTH-2:0], pred};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= StHunt;
            sh_q      <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_q     <= '0;
            win_err_q <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (en_i) begin
                unique case (state_q)
                    StHunt: begin
                        sh_q <= sh_rx_d;
                        if (fill_q == FW'(WIDTH - 1)) begin
                            fill_q <= '0;
                            // An all-zero fill is the LFSR lock-up state; keep hunting.
                            if (sh_rx_d != '0) begin
                                state_q <= StVerify;
                                match_q <= '0;
                            end
                        end else begin
                            fill_q <= fill_q + FW'(1);
                        end
                    end
                    StVerify: begin
                        sh_q <= sh_rx_d;
                        if (mismatch) begin
                            state_q <= StHunt;
                            fill_q  <= '0;
                        end else if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_q   <= StLocked;
                            locked_q  <= 1'b1;
                            win_q     <= '0;
                            win_err_q <= '0;
                        end else begin
                            match_q <= match_q + MW'(1);
                        end
                    end
                    StLocked: begin
                        sh_q <= sh_fly_d;
                        if (mismatch) begin
                            err_q <= 1'b1;
                            if (!(&err_cnt_q)) begin
                                err_cnt_q <= err_cnt_q + ERR_W'(1);
                            end
                        end
                        if (mismatch && (win_err_q == EW'(LOSS_ERR - 1))) begin
                            state_q  <= StHunt;
                            locked_q <= 1'b0;
                            fill_q   <= '0;
                        end else if (win_q == WW'(WINDOW - 1)) begin
                            win_q     <= '0;
                            win_err_q <= '0;
                        end else begin
                            win_q <= win_q + WW'(1);
                            if (mismatch) begin
                                win_err_q <= win_err_q + EW'(1);
                            end
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
            if (clear_i) begin
                err_cnt_q <= '0;
            end
        end
    end

`ifdef LFSR_CHECKER_BITCNT_EN
    logic [31:0] bit_cnt_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            bit_cnt_q <= '0;
        end else if (clear_i) begin
            bit_cnt_q <= '0;
        end else if (en_i && (state_q == StLocked) && !(&bit_cnt_q)) begin
            bit_cnt_q <= bit_cnt_q + 32'd1;
        end
    end

    assign bit_cnt_o = bit_cnt_q;
`endif

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a spec-level acquisition/lock model predicts
// the outputs for every driven cycle; the DUT result is compared one edge later.
module tb_lfsr_checker;

    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic        bit_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        locked_o;
    logic        err_o;
    logic [15:0] err_cnt_o;
    logic [1:0]  state_o;
`ifdef LFSR_CHECKER_BITCNT_EN
    logic [31:0] bit_cnt_o;
`endif

    lfsr_checker dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .en_i       (en_i),
        .bit_i      (bit_i),
        .clear_i    (clear_i),
        .locked_o   (locked_o),
        .err_o      (err_o),
        .err_cnt_o  (err_cnt_o),
        .state_o    (state_o)
`ifdef LFSR_CHECKER_BITCNT_EN
        ,
        .bit_cnt_o  (bit_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic        lk;
        logic        er;
        logic [15:0] cnt;
        logic [31:0] bc;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;

    // Transmitter (pseudo-equivalent) state
    logic [15:0] gen_s = 16'hACE1;

    // Spec-level checker model
    int          m_state;
    int          m_k;
    int          m_wpos;
    int          m_werr;
    logic [15:0] m_cnt;
    logic [31:0] m_bitcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_k      = 0;
        m_wpos   = 0;
        m_werr   = 0;
        m_cnt    = '0;
        m_bitcnt = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked_o), 0);
        chk({tag, "_err"}, 32'(err_o), 0);
        chk({tag, "_cnt"}, 32'(err_cnt_o), 0);
        chk({tag, "_state"}, 32'(state_o), 0);
    endtask

    // Acquisition phases are driven clean; errors are only injected while locked.
    task automatic model_bit(input logic flip, output logic er);
        er = 1'b0;
        if (m_state != 2) begin
            m_k++;
            if (m_k >= 48) begin
                m_state = 2;
                m_wpos  = 0;
                m_werr  = 0;
            end else begin
                m_state = (m_k >= 16) ? 1 : 0;
            end
        end else begin
            if (m_bitcnt != 32'hFFFF_FFFF) m_bitcnt++;
            if (flip) begin
                er = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt++;
                m_werr++;
            end
            if (m_werr == 8) begin
                m_state = 0;
                m_k     = 0;
            end else begin
                m_wpos++;
                if (m_wpos == 64) begin
                    m_wpos = 0;
                    m_werr = 0;
                end
            end
        end
    endtask

    task automatic step(input logic en, input logic flip, input logic clr);
        exp_t e;
        exp_t got;
        logic fb;
        logic er;
        @(negedge clk);
        en_i    = en;
        clear_i = clr;
        er      = 1'b0;
        if (en) begin
            fb    = ^(gen_s & TAPS);
            gen_s = {gen_s[14:0], fb};
            bit_i = fb ^ flip;
            model_bit(flip, er);
        end else begin
            bit_i = 1'($urandom);
        end
        if (clr) begin
            m_cnt    = '0;
            m_bitcnt = '0;
        end
        e.st  = 2'(m_state);
        e.lk  = (m_state == 2);
        e.er  = er;
        e.cnt = m_cnt;
        e.bc  = m_bitcnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("state", 32'(state_o), 32'(got.st));
        chk("locked", 32'(locked_o), 32'(got.lk));
        chk("err", 32'(err_o), 32'(got.er));
        chk("err_cnt", 32'(err_cnt_o), 32'(got.cnt));
`ifdef LFSR_CHECKER_BITCNT_EN
        chk("bit_cnt", bit_cnt_o, got.bc);
`endif
    endtask

    task automatic align_window();
        for (int i = 0; i < 64 && m_wpos != 0; i++) step(1'b1, 1'b0, 1'b0);
        chk("align_wpos", 32'(m_wpos), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en_i    = 1'b0;
        clear_i = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();

        // Reset held low with random input activity
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en_i    = 1'($urandom);
            bit_i   = 1'($urandom);
            clear_i = 1'($urandom);
            @(posedge clk);
            #1;
            chk_zero("in_reset");
        end
        @(negedge clk);
        en_i    = 1'b0;
        clear_i = 1'b0;
        rst_n   = 1'b1;
        #1;
        chk("rel_state", 32'(state_o), 0);

        // Clean acquisition followed by a long clean stream
        for (int i = 0; i < 10000; i++) step(1'b1, 1'b0, 1'b0);
        chk("clean_locked", 32'(locked_o), 1);
        chk("clean_cnt", 32'(err_cnt_o), 0);

        // Single error: flywheel keeps later bits matching
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
        chk("single_cnt", 32'(err_cnt_o), 1);

        // Seven errors in every 64-bit span must not drop lock
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 64; i++) step(1'b1, (i % 9 == 0) && (i < 63), 1'b0);
        chk("seven_locked", 32'(locked_o), 1);
        chk("seven_cnt", 32'(err_cnt_o), 22);

        // Clear coincident with an error
        step(1'b1, 1'b1, 1'b1);
        chk("clr_race_cnt", 32'(err_cnt_o), 0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

        // Error on the window-completing bit, then one more in the next window
        align_window();
        for (int i = 0; i < 64; i++) step(1'b1, i >= 57, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        chk("wrap_locked", 32'(locked_o), 1);

        // Loss of lock on the 8th error within one window
        step(1'b1, 1'b0, 1'b1);
        align_window();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        chk("loss_locked", 32'(locked_o), 0);
        chk("loss_cnt", 32'(err_cnt_o), 8);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b0);
        chk("relock_locked", 32'(locked_o), 1);
        chk("relock_cnt", 32'(err_cnt_o), 8);

        // All-zero stream never leaves HUNT
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            en_i  = 1'b1;
            bit_i = 1'b0;
            @(posedge clk);
            #1;
            chk("zero_state", 32'(state_o), 0);
        end

        // Gapped input at 50% duty locks at the same valid-bit count
        do_reset();
        for (int i = 0; i < 140; i++) step(i[0] == 1'b0, 1'b0, 1'b0);
        chk("gap_locked", 32'(locked_o), 1);

        // Asynchronous reset pulse mid-LOCKED, then relock
        @(negedge clk);
        en_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        en_i  = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'b0);
        chk("async_relock", 32'(locked_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the `pseudo` LFSR generator. It consumes the serial pseudo-random bit stream that a `pseudo` instance drives out on IO pads, self-synchronizes to it, and flags every bit that differs from the predicted sequence. It sits behind `pseudo_wrapper`-style IO muxing on the same user clock and gives a link/loopback bit-error-rate monitor.

## Interface
- `WIDTH`, 16: LFSR length in bits (≥ 4).
- `TAPS`, 16'hB400: Fibonacci tap mask, polynomial x^16+x^14+x^13+x^11+1; bit i set means stage i is XORed.
- `LOCK_CNT`, 32: consecutive correct predictions required to declare lock.
- `WINDOW`, 64: length in valid bits of the loss-of-lock observation window.
- `LOSS_ERR`, 8: errors within one window that force loss of lock.
- `ERR_W`, 16: error counter width.

Ports:
- `wb_clk_i` in 1: single clock; all logic is rising-edge.
- `wb_rst_n_i` in 1: asynchronous, active-low reset.
- `en_i` in 1: `bit_i` is valid this cycle.
- `bit_i` in 1: received serial bit.
- `clear_i` in 1: synchronous clear of `err_cnt_o` (and `bit_cnt_o` when present).
- `locked_o` out 1: checker is in LOCKED.
- `err_o` out 1: one-cycle pulse when a mismatch is detected while LOCKED.
- `err_cnt_o` out ERR_W: saturating count of LOCKED mismatches.
- `state_o` out 2: 0 = HUNT, 1 = VERIFY, 2 = LOCKED.

## Operation
- Shadow register `sh[WIDTH-1:0]`. Prediction `p = ^(sh & TAPS)`. On a valid bit: `sh <= {sh[WIDTH-2:0], d}`. In HUNT and VERIFY, `d` = `bit_i`. In LOCKED, `d` = `p` (flywheel, so errors do not corrupt the prediction).
- Cycles with `en_i` = 0 change no state, counter, or output (`err_o` = 0).
- HUNT:
  - The fill counter counts valid bits.
  - When WIDTH bits have been shifted in and the resulting `sh` ≠ 0, go to VERIFY with match count 0.
  - If the resulting `sh` = 0 (lock-up state), restart the fill counter and stay in HUNT.
- VERIFY:
  - Each valid bit compares `bit_i` with `p`.
  - On a match, the match count increments. On the LOCK_CNT-th match, go to LOCKED and clear the window counter and the window error count.
  - On a mismatch, go to HUNT with the fill counter at 0. No `err_o` is raised and `err_cnt_o` does not change.
- LOCKED:
  - Each valid bit compares `bit_i` with `p`.
  - On a mismatch, pulse `err_o`, increment `err_cnt_o` (saturating at all-ones), and increment the window error count.
  - The window counter wraps after WINDOW valid bits and then clears the window error count.
  - When the window error count reaches LOSS_ERR, go to HUNT (fill counter 0). `err_cnt_o` is retained.
- `clear_i` in the same cycle as an error: the clear wins and `err_cnt_o` becomes 0.
- All outputs are registered.

## Timing
- Reset values:
  - `locked_o` = 0, `err_o` = 0, `err_cnt_o` = 0, `state_o` = 0.
  - `sh` = 0, and all internal counters = 0.
- `err_o` and `err_cnt_o` update on the clock edge that samples the erroneous bit, so they are visible one cycle after the bit is presented.
- `locked_o` rises at the edge sampling the LOCK_CNT-th match.
- With a clean stream, minimum lock time is WIDTH + LOCK_CNT valid bits (48 at defaults).
- `locked_o` falls at the edge sampling the LOSS_ERR-th error in a window.
- An error on the bit that completes a window counts toward that window, then the window error count clears.
- Asserting `wb_rst_n_i` mid-operation immediately returns all state and outputs to the reset values, independent of the clock.

## Configuration
- `LFSR_CHECKER_BITCNT_EN`, when defined:
  - Adds output `bit_cnt_o` (out, 32): saturating count of valid bits checked while LOCKED.
  - It is cleared by reset and by `clear_i`, and retained through loss of lock.
- When undefined, the port and its counter are absent and behaviour is otherwise identical.

## Test plan
- Reset check: with `wb_rst_n_i` low and random `en_i`/`bit_i`, all outputs stay 0. Release reset -> `state_o` = 0.
- Clean lock: feed a `pseudo`-equivalent stream seeded with 16'hACE1, `en_i` = 1 continuously -> `state_o` = 1 after bit 16, `locked_o` = 1 after bit 48, and `err_cnt_o` = 0 over 10,000 bits.
- Single error: invert one bit after lock -> exactly one `err_o` pulse one cycle later, `err_cnt_o` = 1, `locked_o` stays 1, and later bits match (flywheel).
- Loss of lock:
  - Invert 8 bits within one 64-bit window -> `locked_o` falls on the 8th error and `err_cnt_o` = 8.
  - Seven errors per window -> lock is held.
- Degenerate and gapped input:
  - An all-zero stream never leaves HUNT.
  - Toggling `en_i` at 50% duty gives the same lock point in valid-bit count.
  - `en_i` = 0 cycles leave all state unchanged.
- Clear and reset races:
  - `clear_i` coincident with an error -> `err_cnt_o` = 0.
  - Asynchronous reset pulse mid-LOCKED -> immediate return to reset values, then relock after 48 bits.
